// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3 -- rate-1/2 convolutional encoder (K=3, G0=111, G1=101).
//
// Takes a framed serial bit stream and emits one 2-bit symbol per input bit.
// After the frame's data bits it appends K-1 zero tail bits, so the decoder's
// trellis ends in state 0. The output is a single registered symbol with a
// valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   start_i      frame start request, sampled only in IDLE
//   frame_len_i  data bits in the frame, latched when the start is accepted
//   in_valid_i   data_i is valid
//   in_ready_o   encoder accepts data_i this cycle
//   data_i       serial data bit
//   sym_valid_o  sym_o is valid
//   sym_ready_i  downstream consumes sym_o this cycle
//   sym_o        encoded symbol {G0 parity, G1 parity}
//   busy_o       high in any state other than IDLE
//   done_o       one-cycle pulse after the last tail symbol is consumed
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i with a non-zero frame length
// DATA  | encoding data bits until the remaining count reaches zero
// FLUSH | encoding K-1 zero tail bits
// DONE  | waiting for the last tail symbol to leave, then pulse done

module conv_encoder_k3 #(
    parameter int             K     = 3,
    parameter logic [K-1:0]   G0    = 3'b111,
    parameter logic [K-1:0]   G1    = 3'b101,
    parameter int             LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             data_i,
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output logic [1:0]       sym_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int FC_W = $clog2(K);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_FLUSH, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [K-2:0]     sr_q, sr_next;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [FC_W-1:0]  flush_q, flush_d;
    logic [1:0]       sym_q, sym_next;
    logic             sym_valid_q;
    logic             done_q, done_d;
    logic             slot_free;
    logic             load;
    logic             sr_clear;
    logic             enc_bit;
    logic [K-1:0]     window;

    // The symbol slot can take a new value when empty or being drained now.
    assign slot_free   = !sym_valid_q || sym_ready_i;
    assign in_ready_o  = (state_q == S_DATA) && slot_free;
    assign sym_valid_o = sym_valid_q;
    assign sym_o       = sym_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        load        = 1'b0;
        sr_clear    = 1'b0;
        enc_bit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && (frame_len_i != '0)) begin
                    remaining_d = frame_len_i;
                    sr_clear    = 1'b1;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid_i && in_ready_o) begin
                    load        = 1'b1;
                    enc_bit     = data_i;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        flush_d = FC_W'(K - 1);
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    load    = 1'b1;
                    enc_bit = 1'b0;
                    flush_d = flush_q - FC_W'(1);
                    if (flush_q == FC_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window: current bit in the MSB, oldest stored bit in the LSB.
    always_comb begin
        window[K-1] = enc_bit;
        for (int i = 0; i < K - 1; i++) begin
            window[K-2-i] = sr_q[i];
        end
        sym_next = {^(window & G0), ^(window & G1)};
        sr_next[0] = enc_bit;
        for (int i = 1; i < K - 1; i++) begin
            sr_next[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            remaining_q <= '0;
            flush_q     <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            if (sr_clear) begin
                sr_q <= '0;
            end else if (load) begin
                sr_q <= sr_next;
            end
            // A load in the same cycle as a consume replaces the symbol with no bubble.
            if (load) begin
                sym_q       <= sym_next;
                sym_valid_q <= 1'b1;
            end else if (sym_ready_i) begin
                sym_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
module tb_conv_encoder_k3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] frame_len_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       data_i;
    logic       sym_valid_o;
    logic       sym_ready_i;
    logic [1:0] sym_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    logic [1:0] m_sr;
    bit         frame_bits[0:255];

    conv_encoder_k3 dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .frame_len_i (frame_len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .sym_valid_o (sym_valid_o),
        .sym_ready_i (sym_ready_i),
        .sym_o       (sym_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Reference encoder: sr[0] previous bit, sr[1] the one before.
    function automatic logic [1:0] ref_enc(input logic b, input logic [1:0] sr);
        logic p0, p1;
        p0 = b ^ sr[0] ^ sr[1];
        p1 = b ^ sr[1];
        return {p0, p1};
    endfunction

    // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready and valid.
    task automatic run_frame(input int len, input int rmode, input bit skip_start,
                             input bit poke_start, input int chain_len, input string name);
        int         sent, consumed, budget;
        bit         prev_stall, fin, exp_rdy;
        logic [1:0] prev_sym, exp_sym;
        sent = 0; consumed = 0; prev_stall = 0; fin = 0; prev_sym = 2'b00;
        budget = 10 * len + 100;
        exp_q.delete();
        m_sr = 2'b00;
        if (!skip_start) begin
            @(negedge clk);
            start_i = 1'b1;
            frame_len_i = len[7:0];
        end
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start_i     = poke_start && (cyc == 2);
            frame_len_i = 8'd7;
            case (rmode)
                0:       sym_ready_i = 1'b1;
                1:       sym_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: sym_ready_i = 1'($urandom_range(0, 1));
            endcase
            in_valid_i = (sent < len) && (rmode != 2 || $urandom_range(0, 3) != 0);
            data_i     = (sent < len) ? frame_bits[sent] : 1'b0;
            #1;
            exp_rdy = (sent < len) && (!sym_valid_o || sym_ready_i);
            checks++;
            if (in_ready_o !== exp_rdy) begin
                failures++;
                $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", name, cyc, in_ready_o, exp_rdy);
            end
            checks++;
            if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL %s busy/done mid-frame cyc=%0d got busy=%b done=%b exp busy=1 done=0",
                         name, cyc, busy_o, done_o);
            end
            if (prev_stall) begin
                checks++;
                if (sym_valid_o !== 1'b1 || sym_o !== prev_sym) begin
                    failures++;
                    $display("FAIL %s stall_stable cyc=%0d got v=%b sym=%b exp v=1 sym=%b",
                             name, cyc, sym_valid_o, sym_o, prev_sym);
                end
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(ref_enc(data_i, m_sr));
                m_sr = {m_sr[0], data_i};
                sent++;
                if (sent == len) begin
                    for (int t = 0; t < 2; t++) begin
                        exp_q.push_back(ref_enc(1'b0, m_sr));
                        m_sr = {m_sr[0], 1'b0};
                    end
                end
            end
            if (sym_valid_o && sym_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_symbol cyc=%0d got=%b exp=none", name, cyc, sym_o);
                end else begin
                    exp_sym = exp_q.pop_front();
                    if (sym_o !== exp_sym) begin
                        failures++;
                        $display("FAIL %s symbol #%0d got=%b exp=%b", name, consumed, sym_o, exp_sym);
                    end
                end
                consumed++;
            end
            prev_stall = sym_valid_o && !sym_ready_i;
            prev_sym   = sym_o;
            if (consumed == len + 2) begin
                fin = 1'b1;
                break;
            end
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL %s timeout consumed=%0d exp=%0d", name, consumed, len + 2);
        end
        @(negedge clk);
        sym_ready_i = 1'b1;
        in_valid_i  = 1'b0;
        start_i     = (chain_len != 0);
        frame_len_i = chain_len[7:0];
        #1;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || sym_valid_o !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s done_pulse got done=%b busy=%b valid=%b left=%0d exp done=1 busy=0 valid=0 left=0",
                     name, done_o, busy_o, sym_valid_o, exp_q.size());
        end
        if (chain_len == 0) begin
            @(negedge clk);
            #1;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL %s done_once got done=%b busy=%b exp done=0 busy=0", name, done_o, busy_o);
            end
        end
    endtask

    task automatic load_basic();
        frame_bits[0] = 1; frame_bits[1] = 0; frame_bits[2] = 1; frame_bits[3] = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; frame_len_i = 8'd0; in_valid_i = 1'b0;
        data_i = 1'b0; sym_ready_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({sym_valid_o, sym_o, in_ready_o, busy_o, done_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b sym=%b rdy=%b busy=%b done=%b exp all 0",
                     sym_valid_o, sym_o, in_ready_o, busy_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [1:0] golden[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        load_basic();
        // Cross-check the reference model against the hand-worked sequence.
        m_sr = 2'b00;
        for (int i = 0; i < 6; i++) begin
            logic b;
            b = (i < 4) ? frame_bits[i] : 1'b0;
            checks++;
            if (ref_enc(b, m_sr) !== golden[i]) begin
                failures++;
                $display("FAIL basic_golden #%0d got=%b exp=%b", i, ref_enc(b, m_sr), golden[i]);
            end
            m_sr = {m_sr[0], b};
        end
        run_frame(4, 0, 1'b0, 1'b0, 0, "basic");
    endtask

    task automatic test_backpressure();
        load_basic();
        run_frame(4, 1, 1'b0, 1'b0, 0, "backpressure");
        for (int i = 0; i < 12; i++) frame_bits[i] = 1'($urandom_range(0, 1));
        run_frame(12, 2, 1'b0, 1'b0, 0, "random_stall");
    endtask

    task automatic test_zero_and_ignored_start();
        @(negedge clk);
        start_i = 1'b1; frame_len_i = 8'd0;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (busy_o !== 1'b0 || sym_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL zero_len got busy=%b valid=%b exp busy=0 valid=0", busy_o, sym_valid_o);
            end
            @(negedge clk);
        end
        load_basic();
        run_frame(4, 0, 1'b0, 1'b1, 0, "ignored_start");
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 255; i++) frame_bits[i] = 1'($urandom_range(0, 1));
        run_frame(255, 0, 1'b0, 1'b0, 0, "max_len");
        checks++;
        if (m_sr !== 2'b00) begin
            failures++;
            $display("FAIL max_len model_sr got=%b exp=00", m_sr);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        start_i = 1'b1; frame_len_i = 8'd4;
        @(negedge clk);
        start_i = 1'b0; sym_ready_i = 1'b1; in_valid_i = 1'b1; data_i = 1'b1;
        @(negedge clk);
        data_i = 1'b0;
        @(negedge clk);
        in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (sym_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0 || sym_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid got v=%b busy=%b rdy=%b sym=%b exp all 0",
                     sym_valid_o, busy_o, in_ready_o, sym_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done got done=%b busy=%b exp 0 0", done_o, busy_o);
        end
        load_basic();
        run_frame(4, 0, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        load_basic();
        run_frame(4, 0, 1'b0, 1'b0, 1, "b2b_first");
        frame_bits[0] = 1;
        run_frame(1, 0, 1'b1, 1'b0, 0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_ignored_start();
        test_max_len();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
